fpu_axis_pipe: RTL and testbench
================================

Name: fpu_axis_pipe

Overview:
- Parametrised, pipelined client-side wrapper for a two-operand AXI-Stream floating-point IP core (adder/subtractor, multiplier, etc.).
- Successor to the single-shot stop-and-wait FP wrappers: accepts a new request every cycle, keeps up to DEPTH operations in flight, and tags each request.
- Runtime negate-B mode lets one adder IP serve both fadd and fsub.
- Sits between the execute stage and the IP; results return in order with their tag through a buffered, back-pressurable response port.

Parameters:
DATA_W, 32, operand/result width; MSB is the sign bit.
TAG_W, 5, width of the request tag (e.g. destination register index).
DEPTH, 4, max operations between request accept and response handshake; power of two, ≥2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_a  in  DATA_W  operand A
req_b  in  DATA_W  operand B
req_neg_b  in  1  1: invert sign bit of B before issue (subtract mode)
req_tag  in  TAG_W  tag returned with result
m_axis_a_tdata  out  DATA_W  IP operand A
m_axis_a_tvalid  out  1
m_axis_a_tready  in  1
m_axis_b_tdata  out  DATA_W  IP operand B
m_axis_b_tvalid  out  1
m_axis_b_tready  in  1
s_axis_result_tdata  in  DATA_W  IP result
s_axis_result_tvalid  in  1
s_axis_result_tready  out  1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
rsp_data  out  DATA_W  result
rsp_tag  out  TAG_W  tag of this result
inflight  out  $clog2(DEPTH)+1  current credit count
busy  out  1  any operation pending anywhere
err  out  1  sticky: result received with no pending tag

Behaviour:
- Reset (rst=1 at posedge): m_axis_a/b_tvalid=0, m_axis_a/b_tdata=0, s_axis_result_tready=0, rsp_valid=0, rsp_data=0, rsp_tag=0, inflight=0, err=0; tag FIFO and result FIFO emptied. Reset mid-operation discards all in-flight work; the IP must be reset by the same rst.
- s_axis_result_tready is registered; it is 1 in every cycle after reset deasserts. The credit scheme guarantees result FIFO space, so it never drops.
- Credit counter inflight:
  - +1 on request accept, -1 on response handshake; both in the same cycle → unchanged.
  - Never exceeds DEPTH.
- req_ready = (inflight<DEPTH) && (~m_axis_a_tvalid || m_axis_a_tready) && (~m_axis_b_tvalid || m_axis_b_tready).
  - Combinational from tready; allows back-to-back issue.
  - At inflight==DEPTH, req_ready=0 even if a response drains that cycle; the freed credit is usable next cycle.
- Issue: on accept in cycle N, from cycle N+1:
  - m_axis_a_tdata=req_a, m_axis_a_tvalid=1.
  - m_axis_b_tdata=req_neg_b ? {~req_b[DATA_W-1], req_b[DATA_W-2:0]} : req_b, m_axis_b_tvalid=1.
  - Sign flip applies unconditionally, including NaN/zero.
  - req_tag is pushed into the tag FIFO (depth DEPTH) in cycle N.
- A and B channels are independent: each tvalid clears on its own valid&&ready handshake, unless a new accept reloads it in that same cycle. tdata is held stable while tvalid=1.
- Result capture: on s_axis_result_tvalid&&tready, pop the tag FIFO and push {tag, tdata} into the result FIFO (depth DEPTH).
  - If the tag FIFO is empty: set err=1, drop the result, leave the FIFOs unchanged.
  - err clears only on rst.
- Response: rsp_valid=result FIFO non-empty; rsp_data/rsp_tag show the FIFO head.
  - rsp_valid rises the cycle after the result handshake.
  - Results are in order (IP is in-order).
  - Push and pop of the result FIFO in the same cycle are both honoured.
  - FIFO pointers wrap modulo DEPTH.
- Minimum latency, request accept to rsp_valid: 1 + IP latency + 1 cycles.
- busy = (inflight!=0) || m_axis_a_tvalid || m_axis_b_tvalid.

Test Plan:
- Single add: req_a=0x3FC00000 (1.5), req_b=0x40100000 (2.25), neg_b=0, tag=7; IP returns 0x40700000 → rsp_data=0x40700000, rsp_tag=7, inflight 1→0, busy low afterwards.
- Subtract mode: req_a=0x40400000 (3.0), req_b=0x3F800000, neg_b=1 → m_axis_b_tdata=0xBF800000, result 0x40000000 returned with its tag.
- Credit stall: rsp_ready=0, issue 6 requests with tags 1..6 → exactly 4 accepted, req_ready=0 at inflight=4; raise rsp_ready → tags 1,2,3,4 in order, then 5,6 accepted and returned.
- Skewed handshakes: m_axis_a_tready=1, m_axis_b_tready held 0 for 3 cycles → a_tvalid drops after 1 cycle, b_tvalid held with stable data, req_ready=0 until B completes; no duplicate or lost operand.
- Full-boundary simultaneity: inflight=4, response handshake with req_valid=1 in the same cycle → req_ready=0 that cycle, inflight=3 next, the request is accepted the following cycle.
- Spurious result and reset: result tvalid with no pending tag → err=1, rsp_valid stays 0. Assert rst with 3 in flight → all outputs at reset values next cycle; err=0, inflight=0.

Source files
------------

// File: rtl/fpu_axis_pipe_if.sv
// Request, IP-side AXI-Stream and response signals of fpu_axis_pipe.
// slave is the wrapper's view, master is the surrounding logic's view.
interface fpu_axis_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              req_neg_b;
  logic [TAG_W-1:0]  req_tag;

  logic [DATA_W-1:0] m_axis_a_tdata;
  logic              m_axis_a_tvalid;
  logic              m_axis_a_tready;
  logic [DATA_W-1:0] m_axis_b_tdata;
  logic              m_axis_b_tvalid;
  logic              m_axis_b_tready;

  logic [DATA_W-1:0] s_axis_result_tdata;
  logic              s_axis_result_tvalid;
  logic              s_axis_result_tready;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;

  modport slave (
    input  req_valid, req_a, req_b,
    input  req_neg_b, req_tag,
    output req_ready,
    output m_axis_a_tdata, m_axis_a_tvalid,
    input  m_axis_a_tready,
    output m_axis_b_tdata, m_axis_b_tvalid,
    input  m_axis_b_tready,
    input  s_axis_result_tdata,
    input  s_axis_result_tvalid,
    output s_axis_result_tready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b,
    output req_neg_b, req_tag,
    input  req_ready,
    input  m_axis_a_tdata, m_axis_a_tvalid,
    output m_axis_a_tready,
    input  m_axis_b_tdata, m_axis_b_tvalid,
    output m_axis_b_tready,
    output s_axis_result_tdata,
    output s_axis_result_tvalid,
    input  s_axis_result_tready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/fpu_axis_pipe.sv
// Pipelined, tagged client wrapper for a two-operand AXI-Stream FP core.
// Credits bound the ops in flight so the result FIFO can never overflow.
module fpu_axis_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  fpu_axis_pipe_if.slave         io,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                   busy,
  output logic                   err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic              a_vld;
  logic              b_vld;
  logic [DATA_W-1:0] a_dat;
  logic [DATA_W-1:0] b_dat;
  logic [DATA_W-1:0] b_next;
  logic              s_rdy;

  logic              a_free;
  logic              b_free;
  logic              acc;
  logic              res_hs;
  logic              res_push;
  logic              rsp_hs;
  logic              tag_has;

  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [PW-1:0]     t_wr;
  logic [PW-1:0]     t_rd;
  logic [CW-1:0]     t_cnt;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CW-1:0]     r_cnt;

  assign a_free = ~a_vld | io.m_axis_a_tready;
  assign b_free = ~b_vld | io.m_axis_b_tready;

  // A freed credit only becomes usable the cycle after the drain.
  assign io.req_ready = (inflight < CW'(DEPTH))
                      & a_free & b_free;

  assign acc      = io.req_valid & io.req_ready;
  assign res_hs   = io.s_axis_result_tvalid & s_rdy;
  assign tag_has  = t_cnt != '0;
  assign res_push = res_hs & tag_has;

  assign io.rsp_valid = r_cnt != '0;
  assign rsp_hs       = io.rsp_valid & io.rsp_ready;
  assign io.rsp_data  = io.rsp_valid ? r_data[r_rd] : '0;
  assign io.rsp_tag   = io.rsp_valid ? r_tag[r_rd] : '0;

  assign b_next = io.req_neg_b
    ? {~io.req_b[DATA_W-1], io.req_b[DATA_W-2:0]}
    : io.req_b;

  assign io.m_axis_a_tdata  = a_dat;
  assign io.m_axis_a_tvalid = a_vld;
  assign io.m_axis_b_tdata  = b_dat;
  assign io.m_axis_b_tvalid = b_vld;
  assign io.s_axis_result_tready = s_rdy;

  assign busy = (inflight != '0) | a_vld | b_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld    <= 1'b0;
      b_vld    <= 1'b0;
      a_dat    <= '0;
      b_dat    <= '0;
      s_rdy    <= 1'b0;
      inflight <= '0;
      err      <= 1'b0;
      t_wr     <= '0;
      t_rd     <= '0;
      t_cnt    <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
    end else begin
      s_rdy <= 1'b1;

      if (acc) begin
        a_vld <= 1'b1;
        a_dat <= io.req_a;
      end else if (io.m_axis_a_tready) begin
        a_vld <= 1'b0;
      end

      if (acc) begin
        b_vld <= 1'b1;
        b_dat <= b_next;
      end else if (io.m_axis_b_tready) begin
        b_vld <= 1'b0;
      end

      inflight <= inflight + CW'(acc) - CW'(rsp_hs);
      t_cnt    <= t_cnt + CW'(acc) - CW'(res_push);
      r_cnt    <= r_cnt + CW'(res_push) - CW'(rsp_hs);

      if (acc)      t_wr <= t_wr + PW'(1);
      if (res_push) t_rd <= t_rd + PW'(1);
      if (res_push) r_wr <= r_wr + PW'(1);
      if (rsp_hs)   r_rd <= r_rd + PW'(1);

      if (res_hs && !tag_has) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) tag_mem[t_wr] <= io.req_tag;
    if (res_push) begin
      r_data[r_wr] <= io.s_axis_result_tdata;
      r_tag[r_wr]  <= tag_mem[t_rd];
    end
  end
endmodule

// File: tb/tb_fpu_axis_pipe.sv
// Directed bench for fpu_axis_pipe; the bench plays the FP IP by hand.
// Inputs change and outputs are sampled around the falling edge.
module tb_fpu_axis_pipe;
  logic       clk;
  logic       rst;
  logic [2:0] inflight;
  logic       busy;
  logic       err;
  int         n_chk;
  int         n_err;

  fpu_axis_pipe_if #(.DATA_W(32), .TAG_W(5)) bus ();

  fpu_axis_pipe #(.DATA_W(32), .TAG_W(5), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .io       (bus),
    .inflight (inflight),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_tvalid: got %b%b expected 00",
               bus.m_axis_a_tvalid, bus.m_axis_b_tvalid);
    end
    n_chk++;
    if (bus.m_axis_a_tdata !== 32'h0 || bus.m_axis_b_tdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_tdata: got %h %h expected 0",
               bus.m_axis_a_tdata, bus.m_axis_b_tdata);
    end
    n_chk++;
    if (bus.s_axis_result_tready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_tready: got %b expected 0", bus.s_axis_result_tready);
    end
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_tag !== 5'h0) begin
      n_err++;
      $display("FAIL rst_rsp: got %b %h %h expected 0 0 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_tag);
    end
    n_chk++;
    if (inflight !== 3'd0 || err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_state: got inflight=%0d err=%b busy=%b expected 0 0 0",
               inflight, err, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.s_axis_result_tready !== 1'b1) begin
      n_err++;
      $display("FAIL tready_up: got %b expected 1", bus.s_axis_result_tready);
    end
  endtask

  task automatic test_single_add;
    bus.req_a = 32'h3FC00000;
    bus.req_b = 32'h40100000;
    bus.req_neg_b = 1'b0;
    bus.req_tag = 5'd7;
    bus.req_valid = 1'b1;
    #1;
    n_chk++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL add_ready: got %b expected 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_chk++;
    if (bus.m_axis_a_tvalid !== 1'b1 || bus.m_axis_a_tdata !== 32'h3FC00000) begin
      n_err++;
      $display("FAIL add_a: got %b %h expected 1 3fc00000",
               bus.m_axis_a_tvalid, bus.m_axis_a_tdata);
    end
    n_chk++;
    if (bus.m_axis_b_tvalid !== 1'b1 || bus.m_axis_b_tdata !== 32'h40100000) begin
      n_err++;
      $display("FAIL add_b: got %b %h expected 1 40100000",
               bus.m_axis_b_tvalid, bus.m_axis_b_tdata);
    end
    n_chk++;
    if (inflight !== 3'd1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL add_inflight: got %0d busy=%b expected 1 1", inflight, busy);
    end
    @(negedge clk);
    n_chk++;
    if (bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL add_tvalid_clr: got %b%b expected 00",
               bus.m_axis_a_tvalid, bus.m_axis_b_tvalid);
    end
    bus.s_axis_result_tdata = 32'h40700000;
    bus.s_axis_result_tvalid = 1'b1;
    @(negedge clk);
    bus.s_axis_result_tvalid = 1'b0;
    n_chk++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h40700000 || bus.rsp_tag !== 5'd7) begin
      n_err++;
      $display("FAIL add_rsp: got %b %h %0d expected 1 40700000 7",
               bus.rsp_valid, bus.rsp_data, bus.rsp_tag);
    end
    n_chk++;
    if (inflight !== 3'd1) begin
      n_err++;
      $display("FAIL add_inflight_hold: got %0d expected 1", inflight);
    end
    @(negedge clk);
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || inflight !== 3'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL add_done: got rsp_valid=%b inflight=%0d busy=%b expected 0 0 0",
               bus.rsp_valid, inflight, busy);
    end
  endtask

  task automatic test_subtract;
    bus.req_a = 32'h40400000;
    bus.req_b = 32'h3F800000;
    bus.req_neg_b = 1'b1;
    bus.req_tag = 5'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_neg_b = 1'b0;
    n_chk++;
    if (bus.m_axis_b_tdata !== 32'hBF800000 || bus.m_axis_a_tdata !== 32'h40400000) begin
      n_err++;
      $display("FAIL sub_operands: got %h %h expected 40400000 bf800000",
               bus.m_axis_a_tdata, bus.m_axis_b_tdata);
    end
    @(negedge clk);
    bus.s_axis_result_tdata = 32'h40000000;
    bus.s_axis_result_tvalid = 1'b1;
    @(negedge clk);
    bus.s_axis_result_tvalid = 1'b0;
    n_chk++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h40000000 || bus.rsp_tag !== 5'd3) begin
      n_err++;
      $display("FAIL sub_rsp: got %b %h %0d expected 1 40000000 3",
               bus.rsp_valid, bus.rsp_data, bus.rsp_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_credit_stall;
    int acc;
    int idx;
    acc = 0;
    idx = 1;
    bus.rsp_ready = 1'b0;
    bus.req_b = 32'h0;
    bus.req_neg_b = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = 1'b1;
      bus.req_tag = 5'(idx);
      bus.req_a = 32'h100 + 32'(idx);
      #1;
      if (bus.req_ready) begin
        acc++;
        idx++;
      end
      @(negedge clk);
    end
    bus.req_tag = 5'(idx);
    bus.req_a = 32'h100 + 32'(idx);
    #1;
    n_chk++;
    if (acc != 4 || inflight !== 3'd4 || bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_credit: got acc=%0d inflight=%0d ready=%b expected 4 4 0",
               acc, inflight, bus.req_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.s_axis_result_tdata = 32'h200 + 32'(k);
      bus.s_axis_result_tvalid = 1'b1;
    end
    @(negedge clk);
    bus.s_axis_result_tvalid = 1'b0;
    #1;
    n_chk++;
    if (bus.rsp_tag !== 5'd1 || bus.rsp_data !== 32'h201 || bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_head: got tag=%0d data=%h ready=%b expected 1 201 0",
               bus.rsp_tag, bus.rsp_data, bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.rsp_tag !== 5'd2 || bus.req_ready !== 1'b1 || bus.req_tag !== 5'd5) begin
      n_err++;
      $display("FAIL stall_drain2: got tag=%0d ready=%b expected 2 1", bus.rsp_tag,
               bus.req_ready);
    end
    @(negedge clk);
    bus.req_tag = 5'd6;
    bus.req_a = 32'h106;
    #1;
    n_chk++;
    if (bus.rsp_tag !== 5'd3 || bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_drain3: got tag=%0d ready=%b expected 3 1", bus.rsp_tag,
               bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_chk++;
    if (bus.rsp_tag !== 5'd4 || bus.rsp_data !== 32'h204 || inflight !== 3'd3) begin
      n_err++;
      $display("FAIL stall_drain4: got tag=%0d data=%h inflight=%0d expected 4 204 3",
               bus.rsp_tag, bus.rsp_data, inflight);
    end
    @(negedge clk);
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || inflight !== 3'd2) begin
      n_err++;
      $display("FAIL stall_empty: got rsp_valid=%b inflight=%0d expected 0 2",
               bus.rsp_valid, inflight);
    end
    bus.s_axis_result_tdata = 32'h205;
    bus.s_axis_result_tvalid = 1'b1;
    @(negedge clk);
    bus.s_axis_result_tdata = 32'h206;
    n_chk++;
    if (bus.rsp_tag !== 5'd5 || bus.rsp_data !== 32'h205) begin
      n_err++;
      $display("FAIL stall_rsp5: got tag=%0d data=%h expected 5 205",
               bus.rsp_tag, bus.rsp_data);
    end
    @(negedge clk);
    bus.s_axis_result_tvalid = 1'b0;
    n_chk++;
    if (bus.rsp_tag !== 5'd6 || bus.rsp_data !== 32'h206) begin
      n_err++;
      $display("FAIL stall_rsp6: got tag=%0d data=%h expected 6 206",
               bus.rsp_tag, bus.rsp_data);
    end
    @(negedge clk);
    n_chk++;
    if (inflight !== 3'd0 || bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_done: got inflight=%0d rsp_valid=%b expected 0 0",
               inflight, bus.rsp_valid);
    end
  endtask

  task automatic test_skewed;
    bus.m_axis_b_tready = 1'b0;
    bus.req_a = 32'h11111111;
    bus.req_b = 32'h22222222;
    bus.req_neg_b = 1'b0;
    bus.req_tag = 5'd9;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_a = 32'h33333333;
    bus.req_b = 32'h44444444;
    bus.req_tag = 5'd10;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (bus.m_axis_b_tvalid !== 1'b1 || bus.m_axis_b_tdata !== 32'h22222222 ||
          bus.req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL skew_hold%0d: got bv=%b bd=%h ready=%b expected 1 22222222 0",
                 c, bus.m_axis_b_tvalid, bus.m_axis_b_tdata, bus.req_ready);
      end
      if (c == 1) begin
        n_chk++;
        if (bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_a_tdata !== 32'h11111111) begin
          n_err++;
          $display("FAIL skew_a_drop: got av=%b ad=%h expected 0 11111111",
                   bus.m_axis_a_tvalid, bus.m_axis_a_tdata);
        end
      end
      @(negedge clk);
    end
    bus.m_axis_b_tready = 1'b1;
    #1;
    n_chk++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL skew_release: got ready=%b expected 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_chk++;
    if (bus.m_axis_a_tdata !== 32'h33333333 || bus.m_axis_b_tdata !== 32'h44444444 ||
        bus.m_axis_a_tvalid !== 1'b1 || bus.m_axis_b_tvalid !== 1'b1 ||
        inflight !== 3'd2) begin
      n_err++;
      $display("FAIL skew_second: got %h %h %b%b inflight=%0d expected 33333333 44444444 11 2",
               bus.m_axis_a_tdata, bus.m_axis_b_tdata, bus.m_axis_a_tvalid,
               bus.m_axis_b_tvalid, inflight);
    end
    @(negedge clk);
    bus.s_axis_result_tdata = 32'h300;
    bus.s_axis_result_tvalid = 1'b1;
    @(negedge clk);
    bus.s_axis_result_tdata = 32'h301;
    n_chk++;
    if (bus.rsp_tag !== 5'd9 || bus.rsp_data !== 32'h300) begin
      n_err++;
      $display("FAIL skew_rsp9: got tag=%0d data=%h expected 9 300",
               bus.rsp_tag, bus.rsp_data);
    end
    @(negedge clk);
    bus.s_axis_result_tvalid = 1'b0;
    n_chk++;
    if (bus.rsp_tag !== 5'd10 || bus.rsp_data !== 32'h301) begin
      n_err++;
      $display("FAIL skew_rsp10: got tag=%0d data=%h expected 10 301",
               bus.rsp_tag, bus.rsp_data);
    end
    @(negedge clk);
    n_chk++;
    if (inflight !== 3'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL skew_done: got inflight=%0d busy=%b expected 0 0", inflight, busy);
    end
  endtask

  task automatic test_full_boundary;
    bus.rsp_ready = 1'b0;
    bus.req_b = 32'h0;
    bus.req_neg_b = 1'b0;
    bus.req_valid = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      bus.req_tag = 5'(k);
      bus.req_a = 32'(k);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      bus.s_axis_result_tdata = 32'h400 + 32'(k);
      bus.s_axis_result_tvalid = 1'b1;
      @(negedge clk);
    end
    bus.s_axis_result_tvalid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_tag = 5'd15;
    bus.req_a = 32'hABCD0015;
    #1;
    n_chk++;
    if (inflight !== 3'd4 || bus.req_ready !== 1'b0 || bus.rsp_tag !== 5'd11) begin
      n_err++;
      $display("FAIL full_same_cycle: got inflight=%0d ready=%b tag=%0d expected 4 0 11",
               inflight, bus.req_ready, bus.rsp_tag);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (inflight !== 3'd3 || bus.req_ready !== 1'b1 || bus.rsp_tag !== 5'd12) begin
      n_err++;
      $display("FAIL full_next: got inflight=%0d ready=%b tag=%0d expected 3 1 12",
               inflight, bus.req_ready, bus.rsp_tag);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_chk++;
    if (inflight !== 3'd3 || bus.m_axis_a_tdata !== 32'hABCD0015 ||
        bus.m_axis_a_tvalid !== 1'b1 || bus.rsp_tag !== 5'd13) begin
      n_err++;
      $display("FAIL full_accept: got inflight=%0d ad=%h av=%b tag=%0d expected 3 abcd0015 1 13",
               inflight, bus.m_axis_a_tdata, bus.m_axis_a_tvalid, bus.rsp_tag);
    end
    @(negedge clk);
    n_chk++;
    if (bus.rsp_tag !== 5'd14 || bus.rsp_data !== 32'h40E) begin
      n_err++;
      $display("FAIL full_rsp14: got tag=%0d data=%h expected 14 40e",
               bus.rsp_tag, bus.rsp_data);
    end
    @(negedge clk);
    bus.s_axis_result_tdata = 32'h40F;
    bus.s_axis_result_tvalid = 1'b1;
    @(negedge clk);
    bus.s_axis_result_tvalid = 1'b0;
    n_chk++;
    if (bus.rsp_tag !== 5'd15 || bus.rsp_data !== 32'h40F) begin
      n_err++;
      $display("FAIL full_rsp15: got tag=%0d data=%h expected 15 40f",
               bus.rsp_tag, bus.rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_spurious_reset;
    bus.s_axis_result_tdata = 32'hDEAD;
    bus.s_axis_result_tvalid = 1'b1;
    @(negedge clk);
    bus.s_axis_result_tvalid = 1'b0;
    n_chk++;
    if (err !== 1'b1 || bus.rsp_valid !== 1'b0 || inflight !== 3'd0) begin
      n_err++;
      $display("FAIL spurious: got err=%b rsp_valid=%b inflight=%0d expected 1 0 0",
               err, bus.rsp_valid, inflight);
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.req_tag = 5'(k);
      bus.req_a = 32'h500 + 32'(k);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.s_axis_result_tdata = 32'h501;
    bus.s_axis_result_tvalid = 1'b1;
    @(negedge clk);
    bus.s_axis_result_tvalid = 1'b0;
    n_chk++;
    if (inflight !== 3'd3 || err !== 1'b1 || bus.rsp_tag !== 5'd1) begin
      n_err++;
      $display("FAIL pre_reset: got inflight=%0d err=%b tag=%0d expected 3 1 1",
               inflight, err, bus.rsp_tag);
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (inflight !== 3'd0 || err !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_data !== 32'h0 || bus.s_axis_result_tready !== 1'b0 ||
        bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_a_tdata !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: got inflight=%0d err=%b rv=%b rd=%h tr=%b av=%b ad=%h expected all 0",
               inflight, err, bus.rsp_valid, bus.rsp_data,
               bus.s_axis_result_tready, bus.m_axis_a_tvalid, bus.m_axis_a_tdata);
    end
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a = 32'h0;
    bus.req_b = 32'h0;
    bus.req_neg_b = 1'b0;
    bus.req_tag = 5'h0;
    bus.m_axis_a_tready = 1'b1;
    bus.m_axis_b_tready = 1'b1;
    bus.s_axis_result_tdata = 32'h0;
    bus.s_axis_result_tvalid = 1'b0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single_add();
    test_subtract();
    test_credit_stall();
    test_skewed();
    test_full_boundary();
    test_spurious_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
